// File: rtl/noisy_channel.sv
// noisy_channel: the channel model between the convolutional encoder and the decoder.
// Accepted symbols can have one bit flipped by the noise input. The flip position
// rotates through the symbol bits on each accepted symbol. Symbols are buffered in
// a 2-entry FIFO that has registered handshake outputs. Saturating counters record
// how many symbols were accepted and how many bits were flipped.
module noisy_channel #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic             noise_sig,
    input  logic             en_sig,
    input  logic             clr_sig,
    input  logic [WIDTH-1:0] enc_sig,
    input  logic             enc_valid,
    output logic             enc_ready,
    output logic [WIDTH-1:0] chan_sig,
    output logic             chan_valid,
    input  logic             chan_ready,
    output logic [CNT_W-1:0] sym_cnt,
    output logic [CNT_W-1:0] flip_cnt
);

    localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             rdy_q, rdy_d;
    logic             vld_q, vld_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0] flip_cnt_q, flip_cnt_d;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] noise_mask;
    logic [WIDTH-1:0] sym_in;

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    assign push = enc_valid & rdy_q;
    assign pop  = vld_q & chan_ready;

    // Place the noise bit at the current flip position and corrupt the incoming symbol.
    always_comb begin
        noise_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            noise_mask[i] = noise_sig && (ptr_q == PTR_W'(i));
        end
        sym_in = en_sig ? (enc_sig ^ noise_mask) : enc_sig;
    end

    // Next FIFO contents and occupancy. The registered ready/valid come from the
    // next occupancy, so chan_ready has no combinational path to enc_ready.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (occ_q)
            EMPTY: begin
                if (push) begin
                    head_d = sym_in;
                    occ_d  = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = sym_in;
                end else if (push) begin
                    tail_d = sym_in;
                    occ_d  = FULL;
                end else if (pop) begin
                    occ_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = ONE;
                end
            end
            default: occ_d = EMPTY;
        endcase
        rdy_d = (occ_d != FULL);
        vld_d = (occ_d != EMPTY);
    end

    // Flip-position pointer and statistics counters. Clear takes priority over counting.
    always_comb begin
        ptr_d = ptr_q;
        if (push) begin
            ptr_d = (ptr_q == PTR_W'(WIDTH - 1)) ? '0 : ptr_q + 1'b1;
        end
        sym_cnt_d  = sym_cnt_q;
        flip_cnt_d = flip_cnt_q;
        if (clr_sig) begin
            sym_cnt_d  = '0;
            flip_cnt_d = '0;
        end else if (push) begin
            sym_cnt_d = sat_inc(sym_cnt_q);
            if (en_sig && noise_sig) begin
                flip_cnt_d = sat_inc(flip_cnt_q);
            end
        end
    end

    // State registers. Reset empties the FIFO immediately, without a clock edge.
    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            occ_q      <= EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            rdy_q      <= 1'b0;
            vld_q      <= 1'b0;
            ptr_q      <= '0;
            sym_cnt_q  <= '0;
            flip_cnt_q <= '0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            rdy_q      <= rdy_d;
            vld_q      <= vld_d;
            ptr_q      <= ptr_d;
            sym_cnt_q  <= sym_cnt_d;
            flip_cnt_q <= flip_cnt_d;
        end
    end

    assign enc_ready  = rdy_q;
    assign chan_valid = vld_q;
    assign chan_sig   = head_q;
    assign sym_cnt    = sym_cnt_q;
    assign flip_cnt   = flip_cnt_q;

endmodule

// File: tb/tb_noisy_channel.sv
// Testbench for noisy_channel. A queue-based reference model is updated on the
// falling edge from the handshakes that the next rising edge will complete. A
// monitor compares every delivered symbol, the handshake flags and the counters.
module tb_noisy_channel;

    localparam int WIDTH = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk_sig = 1'b0;
    logic             reset_sig;
    logic             noise_sig;
    logic             en_sig;
    logic             clr_sig;
    logic [WIDTH-1:0] enc_sig;
    logic             enc_valid;
    logic             enc_ready;
    logic [WIDTH-1:0] chan_sig;
    logic             chan_valid;
    logic             chan_ready;
    logic [CNT_W-1:0] sym_cnt;
    logic [CNT_W-1:0] flip_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_q[$];
    int m_ptr  = 0;
    int m_sym  = 0;
    int m_flip = 0;
    int m_acc  = 0;

    noisy_channel #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_sig   (clk_sig),
        .reset_sig (reset_sig),
        .noise_sig (noise_sig),
        .en_sig    (en_sig),
        .clr_sig   (clr_sig),
        .enc_sig   (enc_sig),
        .enc_valid (enc_valid),
        .enc_ready (enc_ready),
        .chan_sig  (chan_sig),
        .chan_valid(chan_valid),
        .chan_ready(chan_ready),
        .sym_cnt   (sym_cnt),
        .flip_cnt  (flip_cnt)
    );

    always #5 clk_sig = ~clk_sig;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor and scoreboard. Outputs are compared with the model first, and then
    // the model takes in this cycle's handshakes.
    always @(negedge clk_sig) begin
        if (!reset_sig) begin
            exp_q.delete();
            m_ptr  = 0;
            m_sym  = 0;
            m_flip = 0;
        end else begin
            chk("enc_ready", {31'd0, enc_ready}, {31'd0, exp_q.size() < 2});
            chk("chan_valid", {31'd0, chan_valid}, {31'd0, exp_q.size() > 0});
            chk("sym_cnt", 32'(sym_cnt), 32'(m_sym));
            chk("flip_cnt", 32'(flip_cnt), 32'(m_flip));
            if (chan_valid && chan_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(chan_sig), 32'hFFFF_FFFF);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    chk("chan_sig", 32'(chan_sig), 32'(e));
                end
                got_q.push_back(chan_sig);
            end
            if (enc_valid && enc_ready) begin
                logic [WIDTH-1:0] e;
                bit flip;
                flip = en_sig && noise_sig;
                e = enc_sig;
                if (flip) e[m_ptr] = ~e[m_ptr];
                exp_q.push_back(e);
                m_ptr = (m_ptr + 1) % WIDTH;
                m_acc++;
                if (!clr_sig) begin
                    if (m_sym < CMAX) m_sym++;
                    if (flip && m_flip < CMAX) m_flip++;
                end
            end
            if (clr_sig) begin
                m_sym  = 0;
                m_flip = 0;
            end
        end
    end

    // Offer one symbol and hold it until accepted. Returns the number of stalled cycles.
    task automatic send(input logic [WIDTH-1:0] v, input int max_wait, output int waited);
        enc_valid = 1'b1;
        enc_sig   = v;
        waited    = 0;
        forever begin
            @(negedge clk_sig);
            if (enc_ready) break;
            waited++;
            if (waited >= max_wait) begin
                chk("send_timeout", 32'(waited), 32'(max_wait - 1));
                break;
            end
        end
        @(posedge clk_sig);
        #1;
        enc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sig);
        #1;
    endtask

    initial begin
        int w;
        int wsum;
        int acc0;
        bit took;
        logic [WIDTH-1:0] exp_a[4];

        reset_sig  = 1'b0;
        noise_sig  = 1'b0;
        en_sig     = 1'b0;
        clr_sig    = 1'b0;
        enc_sig    = '0;
        enc_valid  = 1'b0;
        chan_ready = 1'b0;
        #12;
        chk("rst_chan_valid", {31'd0, chan_valid}, 32'd0);
        chk("rst_chan_sig", 32'(chan_sig), 32'd0);
        chk("rst_enc_ready", {31'd0, enc_ready}, 32'd0);
        chk("rst_sym_cnt", 32'(sym_cnt), 32'd0);
        chk("rst_flip_cnt", 32'(flip_cnt), 32'd0);
        @(negedge clk_sig);
        #1 reset_sig = 1'b1;
        @(posedge clk_sig);
        #1;
        chk("ready_after_rst", {31'd0, enc_ready}, 32'd1);

        // Back-to-back pass-through
        chan_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 4; i++) send(WIDTH'(i), 5, w);
        idle(3);
        chk("pass_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("pass_val", 32'(got_q[i]), 32'(i));
        chk("pass_sym_cnt", 32'(sym_cnt), 32'd4);
        chk("pass_flip_cnt", 32'(flip_cnt), 32'd0);

        // Constant noise on all-zero symbols walks the flipped bit
        en_sig    = 1'b1;
        noise_sig = 1'b1;
        got_q.delete();
        for (int i = 0; i < 4; i++) send('0, 5, w);
        en_sig    = 1'b0;
        noise_sig = 1'b0;
        idle(3);
        exp_a = '{2'd1, 2'd2, 2'd1, 2'd2};
        chk("noise_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("noise_val", 32'(got_q[i]), 32'(exp_a[i]));
        chk("noise_flip_cnt", 32'(flip_cnt), 32'd4);

        // Backpressure: only two accepted while the decoder stalls
        chan_ready = 1'b0;
        got_q.delete();
        acc0 = m_acc;
        send(2'd1, 5, w);
        send(2'd2, 5, w);
        enc_valid = 1'b1;
        enc_sig   = 2'd3;
        idle(4);
        chk("bp_accepted", 32'(m_acc - acc0), 32'd2);
        chk("bp_enc_ready", {31'd0, enc_ready}, 32'd0);
        chan_ready = 1'b1;
        send(2'd3, 6, w);
        idle(4);
        chk("bp_count", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < got_q.size(); i++) chk("bp_val", 32'(got_q[i]), 32'(i + 1));

        // Saturation at full throughput, then clear against a same-cycle accept
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            send(WIDTH'(i), 5, w);
            wsum += w;
        end
        chk("throughput_stalls", 32'(wsum), 32'd0);
        idle(1);
        chk("sat_sym_cnt", 32'(sym_cnt), 32'(CMAX));
        clr_sig = 1'b1;
        send(2'd0, 5, w);
        clr_sig = 1'b0;
        chk("clr_sym_cnt", 32'(sym_cnt), 32'd0);
        chk("clr_flip_cnt", 32'(flip_cnt), 32'd0);
        idle(3);

        // Asynchronous reset while the FIFO is full
        chan_ready = 1'b0;
        send(2'd2, 5, w);
        send(2'd3, 5, w);
        idle(1);
        chk("full_chan_valid", {31'd0, chan_valid}, 32'd1);
        chk("full_enc_ready", {31'd0, enc_ready}, 32'd0);
        reset_sig = 1'b0;
        #1;
        chk("arst_chan_valid", {31'd0, chan_valid}, 32'd0);
        chk("arst_chan_sig", 32'(chan_sig), 32'd0);
        chk("arst_enc_ready", {31'd0, enc_ready}, 32'd0);
        chk("arst_sym_cnt", 32'(sym_cnt), 32'd0);
        chk("arst_flip_cnt", 32'(flip_cnt), 32'd0);
        @(negedge clk_sig);
        #1 reset_sig = 1'b1;
        idle(1);

        // Random traffic against the model
        took = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk_sig);
            took = enc_valid && enc_ready;
            @(posedge clk_sig);
            #1;
            if (!enc_valid || took) begin
                enc_valid = ($urandom_range(0, 9) < 7);
                enc_sig   = WIDTH'($urandom);
            end
            chan_ready = $urandom_range(0, 1) == 1;
            en_sig     = $urandom_range(0, 1) == 1;
            noise_sig  = $urandom_range(0, 1) == 1;
            clr_sig    = ($urandom_range(0, 99) < 3);
        end
        enc_valid  = 1'b0;
        clr_sig    = 1'b0;
        chan_ready = 1'b1;
        idle(4);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_chan_valid", {31'd0, chan_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
